// File: rtl/max7219_rx_model.sv
// Receive-side model of a MAX7219 daisy chain: oversamples sck/mosi/cs and decodes 16-bit writes.
// Optional MAX7219_FRAMECHK_EN rejects frames whose length is not exactly 16*SIZE bits.
module max7219_rx_model #(
    parameter int SIZE   = 2,
    parameter int SYNC_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sck,
    input  logic                 mosi,
    input  logic                 cs,
    output logic [64*SIZE-1:0]   pixels,
    output logic [4*SIZE-1:0]    intensity,
    output logic [3*SIZE-1:0]    scan_limit,
    output logic [8*SIZE-1:0]    decode,
    output logic [SIZE-1:0]      shutdown_n,
    output logic [SIZE-1:0]      disp_test,
    output logic                 frame_vld,
    output logic                 frame_err,
    output logic [15:0]          frame_cnt
);

    localparam int NBITS = 16 * SIZE;
    localparam int CW    = $clog2(NBITS + 2);
    localparam logic [CW-1:0] CNT_SAT  = CW'(NBITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NBITS);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_W-1:0] sck_sync, mosi_sync, cs_sync;
    logic              sck_prev, cs_prev, mosi_q;
    logic              sck_rise_q, cs_rise_q, cs_fall_q;
    logic [NBITS-1:0]  sr;
    logic [CW-1:0]     bit_cnt;
    state_t            state, state_nxt;
    logic              do_shift, do_commit, do_err, clr_cnt;

    // cs idles high so the synchronizer resets to 1 to avoid a false frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync   <= '0;
            mosi_sync  <= '0;
            cs_sync    <= '1;
            sck_prev   <= 1'b0;
            cs_prev    <= 1'b1;
            mosi_q     <= 1'b0;
            sck_rise_q <= 1'b0;
            cs_rise_q  <= 1'b0;
            cs_fall_q  <= 1'b0;
        end else begin
            sck_sync   <= {sck_sync[SYNC_W-2:0], sck};
            mosi_sync  <= {mosi_sync[SYNC_W-2:0], mosi};
            cs_sync    <= {cs_sync[SYNC_W-2:0], cs};
            sck_prev   <= sck_sync[SYNC_W-1];
            cs_prev    <= cs_sync[SYNC_W-1];
            mosi_q     <= mosi_sync[SYNC_W-1];
            sck_rise_q <= sck_sync[SYNC_W-1] & ~sck_prev;
            cs_rise_q  <= cs_sync[SYNC_W-1] & ~cs_prev;
            cs_fall_q  <= ~cs_sync[SYNC_W-1] & cs_prev;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_shift  = 1'b0;
        do_commit = 1'b0;
        do_err    = 1'b0;
        clr_cnt   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall_q) begin
                    state_nxt = SHIFT;
                    clr_cnt   = 1'b1;
                end
            end
            SHIFT: begin
                // cs rise wins over a coincident sck rise; an empty frame is dropped silently.
                if (cs_rise_q) begin
                    state_nxt = IDLE;
                    if (bit_cnt != '0) begin
`ifdef MAX7219_FRAMECHK_EN
                        if (bit_cnt == CNT_FULL) do_commit = 1'b1;
                        else                     do_err    = 1'b1;
`else
                        do_commit = 1'b1;
`endif
                    end
                end else if (sck_rise_q) begin
                    do_shift = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr         <= '0;
            bit_cnt    <= '0;
            pixels     <= '0;
            intensity  <= '0;
            scan_limit <= '0;
            decode     <= '0;
            shutdown_n <= '0;
            disp_test  <= '0;
            frame_vld  <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_vld <= do_commit;
            frame_err <= do_err;
            if (clr_cnt) begin
                bit_cnt <= '0;
            end else if (do_shift) begin
                sr <= {sr[NBITS-2:0], mosi_q};
                if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
            end
            if (do_commit) begin
                frame_cnt <= frame_cnt + 16'd1;
                // Device 0 is nearest the driver, so it holds the most recently shifted word.
                for (int k = 0; k < SIZE; k++) begin
                    case (sr[16*k+8 +: 4])
                        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
                            pixels[64*k + 8*(int'(sr[16*k+8 +: 4]) - 1) +: 8] <= sr[16*k +: 8];
                        4'h9: decode[8*k +: 8]     <= sr[16*k +: 8];
                        4'hA: intensity[4*k +: 4]  <= sr[16*k +: 4];
                        4'hB: scan_limit[3*k +: 3] <= sr[16*k +: 3];
                        4'hC: shutdown_n[k]        <= sr[16*k];
                        4'hF: disp_test[k]         <= sr[16*k];
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_max7219_rx_model.sv
// Randomized scoreboard bench for max7219_rx_model (SIZE=2, SYNC_W=2).
module tb_max7219_rx_model;

    localparam int SIZE   = 2;
    localparam int SYNC_W = 2;

    logic         clk = 1'b0;
    logic         rst_n, sck, mosi, cs;
    logic [127:0] pixels;
    logic [7:0]   intensity;
    logic [5:0]   scan_limit;
    logic [15:0]  decode;
    logic [1:0]   shutdown_n, disp_test;
    logic         frame_vld, frame_err;
    logic [15:0]  frame_cnt;

    max7219_rx_model #(.SIZE(SIZE), .SYNC_W(SYNC_W)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .cs(cs),
        .pixels(pixels), .intensity(intensity), .scan_limit(scan_limit),
        .decode(decode), .shutdown_n(shutdown_n), .disp_test(disp_test),
        .frame_vld(frame_vld), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] pix;
        logic [7:0]   inten;
        logic [5:0]   scan;
        logic [15:0]  dec;
        logic [1:0]   shdn;
        logic [1:0]   dt;
        logic [15:0]  cnt;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    // Reference state: what each chained device holds, plus the bits last seen on the wire.
    logic [127:0] m_pix;
    logic [7:0]   m_int;
    logic [5:0]   m_scan;
    logic [15:0]  m_dec;
    logic [1:0]   m_shdn, m_dt;
    logic [15:0]  m_cnt;
    logic [31:0]  m_sr;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    task automatic model_reset();
        m_pix = '0; m_int = '0; m_scan = '0; m_dec = '0;
        m_shdn = '0; m_dt = '0; m_cnt = '0; m_sr = '0;
    endtask

    function automatic exp_t snapshot(input logic err);
        exp_t e;
        e.pix = m_pix; e.inten = m_int; e.scan = m_scan; e.dec = m_dec;
        e.shdn = m_shdn; e.dt = m_dt; e.cnt = m_cnt; e.err = err;
        return e;
    endfunction

    // Returns 1 if a pulse (commit or reject) is expected for this frame.
    function automatic bit model_frame(input logic [63:0] bits, input int n);
        logic [95:0] t;
        logic [63:0] mask;
        logic [15:0] w;
        int a;
        mask = (64'd1 << n) - 64'd1;
        t = ({64'd0, m_sr} << n) | {32'd0, bits & mask};
        m_sr = t[31:0];
        if (n == 0) return 1'b0;
`ifdef MAX7219_FRAMECHK_EN
        if (n != 32) begin
            exp_q.push_back(snapshot(1'b1));
            return 1'b1;
        end
`endif
        for (int k = 0; k < SIZE; k++) begin
            w = m_sr[16*k +: 16];
            a = int'(w[11:8]);
            if (a >= 1 && a <= 8) m_pix[64*k + 8*(a-1) +: 8] = w[7:0];
            else if (a == 9)  m_dec[8*k +: 8]  = w[7:0];
            else if (a == 10) m_int[4*k +: 4]  = w[3:0];
            else if (a == 11) m_scan[3*k +: 3] = w[2:0];
            else if (a == 12) m_shdn[k]        = w[0];
            else if (a == 15) m_dt[k]          = w[0];
        end
        m_cnt = m_cnt + 16'd1;
        exp_q.push_back(snapshot(1'b0));
        return 1'b1;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bits(input logic [63:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            wait_clk(2);
            sck = 1'b1;
            wait_clk(4);
            sck = 1'b0;
            wait_clk(2);
        end
    endtask

    task automatic send_frame(input logic [63:0] bits, input int n);
        bit pulse;
        int lat;
        pulse = model_frame(bits, n);
        @(negedge clk);
        cs = 1'b0;
        wait_clk(4);
        drive_bits(bits, n);
        wait_clk(2);
        cs = 1'b1;
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && (frame_vld || frame_err)) lat = c;
        end
        chk("latency", 128'(lat), pulse ? 128'(SYNC_W + 2) : 128'(-1));
        wait_clk(3);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_pixels"}, pixels, '0);
        chk({nm, "_ctrl"}, {intensity, scan_limit, decode, shutdown_n, disp_test}, '0);
        chk({nm, "_flags"}, {frame_vld, frame_err, frame_cnt}, '0);
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (frame_vld || frame_err)) begin
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", {frame_vld, frame_err}, 2'b00);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_vld_err", {frame_vld, frame_err}, {~e.err, e.err});
                chk("mon_pixels", pixels, e.pix);
                chk("mon_intensity", intensity, e.inten);
                chk("mon_scan_limit", scan_limit, e.scan);
                chk("mon_decode", decode, e.dec);
                chk("mon_shutdown_n", shutdown_n, e.shdn);
                chk("mon_disp_test", disp_test, e.dt);
                chk("mon_frame_cnt", frame_cnt, e.cnt);
            end
        end
    end

    initial begin
        logic [7:0]  row;
        logic [15:0] w0, w1;
        int          n, r;
        rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; cs = 1'b1;
        model_reset();
        wait_clk(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        wait_clk(4);

        // Intensity split across devices: far device gets the first word.
        send_frame({32'd0, 16'h0A05, 16'h0A0C}, 32);
        chk("t1_intensity", intensity, 8'h5C);
        chk("t1_frame_cnt", frame_cnt, 16'd1);

        for (int d = 1; d <= 8; d++) begin
            row = 8'($urandom);
            send_frame({32'd0, 16'(d << 8) | {8'h00, row}, 16'(d << 8) | {8'h00, ~row}}, 32);
        end
        chk("t2_pixels", pixels, m_pix);

        send_frame({32'd0, 16'h0C01, 16'h0000}, 32);
        chk("t3_shutdown_n", shutdown_n, 2'b10);

        send_frame(64'h0F01FF, 24);

        // Empty cs pulse: no pulse, count unchanged.
        send_frame(64'd0, 0);
        chk("t6_frame_cnt", frame_cnt, m_cnt);

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            n = (r == 0) ? 0 : (r == 1) ? 8 : (r == 2) ? 24 : (r == 3) ? 40 : 32;
            w0 = 16'($urandom);
            w1 = 16'($urandom);
            send_frame({16'($urandom), 16'($urandom), w1, w0}, n);
        end

        // Reset after 10 bits of a frame.
        @(negedge clk);
        cs = 1'b0;
        wait_clk(4);
        drive_bits(64'h3FF, 10);
        rst_n = 1'b0;
        cs = 1'b1;
        model_reset();
        exp_q.delete();
        wait_clk(2);
        chk_all_zero("t5_reset");
        rst_n = 1'b1;
        wait_clk(6);
        send_frame({32'd0, 16'h0B05, 16'h0307}, 32);
        chk("t5_scan_limit", scan_limit, 6'b101_000);
        chk("t5_pixels", pixels, m_pix);

        wait_clk(10);
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
